// File: rtl/uart_transmitter_fsm.sv
// uart_transmitter_fsm: serializes one byte per frame onto TxD (start, data LSB first,
// optional parity, stop bits), timed by an external 16x baud enable.
module uart_transmitter_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rstb_i,
    input  logic                 baudx16,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 TxD,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);
    localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick, tick_n;
    logic [BW-1:0]        bitc, bitc_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par, par_n;
    logic                 txd_n, ready_n, busy_n, done_n;
    logic                 boundary;

    assign boundary = baudx16 && tick == TICK_LAST;

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state      <= IDLE;
            tick       <= '0;
            bitc       <= '0;
            shift      <= '0;
            par        <= 1'b0;
            TxD        <= 1'b1;
            tx_ready_o <= 1'b1;
            tx_busy_o  <= 1'b0;
            tx_done_o  <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            bitc       <= bitc_n;
            shift      <= shift_n;
            par        <= par_n;
            TxD        <= txd_n;
            tx_ready_o <= ready_n;
            tx_busy_o  <= busy_n;
            tx_done_o  <= done_n;
        end
    end

    // TxD is computed one edge ahead so the pin is always a flop output
    always_comb begin
        state_n = state;
        tick_n  = tick;
        bitc_n  = bitc;
        shift_n = shift;
        par_n   = par;
        txd_n   = TxD;
        ready_n = tx_ready_o;
        busy_n  = tx_busy_o;
        done_n  = 1'b0;
        if (baudx16 && state inside {START, DATA, PARITY, STOP})
            tick_n = boundary ? '0 : tick + 1'b1;
        case (state)
            IDLE: if (tx_valid_i && tx_ready_o) begin
                shift_n = tx_data_i;
                par_n   = ^tx_data_i ^ (PARITY_ODD != 0);
                ready_n = 1'b0;
                busy_n  = 1'b1;
                state_n = WAIT_TICK;
            end
            WAIT_TICK: if (baudx16) begin
                txd_n   = 1'b0;
                tick_n  = '0;
                state_n = START;
            end
            START: if (boundary) begin
                txd_n   = shift[0];
                bitc_n  = '0;
                state_n = DATA;
            end
            DATA: if (boundary) begin
                shift_n = shift >> 1;
                bitc_n  = bitc + 1'b1;
                txd_n   = shift[1];
                if (bitc == DATA_LAST) begin
                    bitc_n  = '0;
                    txd_n   = PARITY_EN != 0 ? par : 1'b1;
                    state_n = PARITY_EN != 0 ? PARITY : STOP;
                end
            end
            PARITY: if (boundary) begin
                txd_n   = 1'b1;
                bitc_n  = '0;
                state_n = STOP;
            end
            STOP: if (boundary) begin
                bitc_n = bitc + 1'b1;
                if (bitc == STOP_LAST) begin
                    bitc_n  = '0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
